axi_gp_reg_slave: RTL and testbench
===================================

Name: axi_gp_reg_slave

Overview:
- Verilog AXI3 slave register block hanging directly off the PS7 MAXIGP0 port. Consumes PS-issued single-beat reads and writes.
- Provides control/status registers, a free-running timer with compare interrupt, LED drive and an IRQF2P interrupt line.
- Replaces the generated peripheral; echoes transaction IDs and drives RLAST itself.

Parameters:
- ID_W, 12, width of AWID/WID/BID/ARID/RID.
- NREGS, 5, number of implemented 32-bit registers; word offsets >= NREGS decode-error.

Ports:
- fclk  in  1  clock (fclk[0] of PS7)
- reset  in  1  synchronous, active-high
- s_awaddr  in  32  write address; only bits [11:0] decoded
- s_awprot  in  3  ignored
- s_awid  in  ID_W  write ID
- s_awvalid / s_awready  in/out  1  AW handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wid  in  ID_W  write-data ID
- s_wvalid / s_wready  in/out  1  W handshake
- s_bresp  out  2  write response
- s_bid  out  ID_W  echo of captured AWID
- s_bvalid / s_bready  out/in  1  B handshake
- s_araddr  in  32  read address; bits [11:0] decoded
- s_arprot  in  3  ignored
- s_arid  in  ID_W  read ID
- s_arvalid / s_arready  in/out  1  AR handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rid  out  ID_W  echo of captured ARID
- s_rlast  out  1  constant 1 (single beat)
- s_rvalid / s_rready  out/in  1  R handshake
- leds  out  2  CTRL[1:0]
- irq  out  1  level interrupt to IRQF2P[0]

Behaviour:
- Clock fclk; reset synchronous active-high. All flops clear. Reset outputs: every ready/valid 0 during reset, then awready=wready=arready=1 on the first cycle after; bresp/rresp/rdata/bid/rid 0; leds 0; irq 0.
- Register map (offset = addr[11:0], word index = addr[11:2]):
  - 0x00 CTRL rw: [1:0] leds, [8] irq_en, other bits read 0.
  - 0x04 STAT: [0] pending. Write 1 to bit0 clears it; write 1 to bit1 sets pending (software trigger). Reads {31'b0,pending}.
  - 0x08 SCRATCH rw 32 bits.
  - 0x0C TIMER ro: increments every cycle, wraps 0xFFFFFFFF->0. Writes are ignored with OKAY.
  - 0x10 CMP rw: when CMP!=0 and TIMER==CMP, pending sets.
  - Offsets not word-aligned use addr[11:2] (low bits ignored).
- irq = pending & irq_en (combinational from flops).
- Pending set and a W1C clear in the same cycle: set wins.
- Write path (AW and W independent):
  - awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
  - Each channel is captured on its handshake.
  - Commit cycle: the first cycle both are held, including same-cycle arrival. Registers update at the end of the commit cycle, bvalid=1 next cycle, bid=held AWID.
  - bresp: 2'b11 DECERR if index >= NREGS. 2'b10 SLVERR if WID != AWID; no register update in this case. Otherwise 2'b00.
  - bvalid holds until bready; held flags clear on the B handshake, after which awready/wready return to 1 the next cycle.
  - Order of AW vs W arrival is irrelevant; W may precede AW by any number of cycles.
- Read path:
  - arready = ~rvalid.
  - AR handshake at cycle N -> rvalid=1 at N+1, with rdata/rresp/rid latched at cycle N.
  - rdata is the value of the register at cycle N, before any write committing in the same cycle.
  - DECERR 2'b11 with rdata=0 for index >= NREGS.
  - rvalid holds until rready; back-to-back reads sustain one read per 2 cycles.
- Read and write paths are fully concurrent.
- Reset mid-transaction: any pending B/R beat is dropped and held flags clear; no register update occurs.

Optional Feature:
- AXI_REG_STRB_EN defined:
  - wstrb byte enables honoured per byte on CTRL, SCRATCH and CMP.
  - STAT acts only if wstrb[0]=1.
  - wstrb=0 yields OKAY with no change.
- AXI_REG_STRB_EN undefined: wstrb is ignored and every accepted write is a full 32-bit write.

Test Plan:
1. AW(0x08, id 0x3) and W(0xDEADBEEF, wid 0x3) in the same cycle -> bvalid next cycle, bresp 00, bid 0x3. Then read 0x08, arid 0x7 -> rvalid 1 cycle after AR, rdata 0xDEADBEEF, rid 0x7, rlast 1.
2. W (wid 0x5, data 0x3) sent 3 cycles before AW(0x00, id 0x5) -> wready low after W handshake, commit on AW cycle, leds=2'b11, bid 0x5.
3. Write CMP=100, then CTRL=0x100 -> irq rises the cycle after TIMER==100. Write STAT=0x1 -> irq 0. Write STAT=0x2 -> irq 1.
4. Read 0x20 -> rresp 11, rdata 0. Write 0x14 -> bresp 11 and all registers unchanged.
5. Hold bready=0 for 5 cycles after a write -> bvalid stays 1, awready/wready stay 0, second AW not accepted until the B handshake. Then WID 0x1 vs AWID 0x2 -> bresp 10, SCRATCH unchanged.
6. With AXI_REG_STRB_EN: SCRATCH=0xDEADBEEF, then write 0x11223344 with wstrb 4'b0101 -> read 0xDE22BE44. Without the macro -> read 0x11223344.

Source files
------------

// File: rtl/axi_gp_reg_slave.sv
// Purpose: AXI3 single-beat register slave for the PS7 MAXIGP0 port. It holds CTRL, STAT,
//          SCRATCH, a free-running TIMER and CMP, drives the LEDs and a level IRQ.
// Latency: B is valid the cycle after AW and W are both held. R is valid the cycle after AR.
// Backpressure: AW/W stall while their beat is held or B is pending. AR stalls while R is
//               pending. B and R hold until their ready.
// Ports:   fclk/reset (sync, active-high); s_aw*/s_w*/s_b* write channels; s_ar*/s_r* read
//          channels; leds = CTRL[1:0]; irq = pending & CTRL[8].
// Build option: define AXI_REG_STRB_EN to honour wstrb per byte. Without it, every accepted
//               write is a full 32-bit write.
module axi_gp_reg_slave #(
  parameter int ID_W  = 12,
  parameter int NREGS = 5
) (
  input  logic            fclk,
  input  logic            reset,
  input  logic [31:0]     s_awaddr,
  input  logic [2:0]      s_awprot,
  input  logic [ID_W-1:0] s_awid,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [31:0]     s_wdata,
  input  logic [3:0]      s_wstrb,
  input  logic [ID_W-1:0] s_wid,
  input  logic            s_wvalid,
  output logic            s_wready,
  output logic [1:0]      s_bresp,
  output logic [ID_W-1:0] s_bid,
  output logic            s_bvalid,
  input  logic            s_bready,
  input  logic [31:0]     s_araddr,
  input  logic [2:0]      s_arprot,
  input  logic [ID_W-1:0] s_arid,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [31:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic [ID_W-1:0] s_rid,
  output logic            s_rlast,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [1:0]      leds,
  output logic            irq
);

  localparam logic [9:0]  NREGS_IDX = 10'(NREGS);
  localparam logic [31:0] CTRL_MASK = 32'h0000_0103;

  // Write-channel capture and response state
  logic            aw_held_q, aw_held_d;
  logic [9:0]      aw_idx_q, aw_idx_d;
  logic [ID_W-1:0] aw_id_q, aw_id_d;
  logic            w_held_q, w_held_d;
  logic [31:0]     w_data_q, w_data_d;
  logic [3:0]      w_strb_q, w_strb_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;

  // Read response state
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [ID_W-1:0] rid_q, rid_d;

  // Register file
  logic [31:0]     ctrl_q, ctrl_d;
  logic            pending_q, pending_d;
  logic [31:0]     scratch_q, scratch_d;
  logic [31:0]     timer_q, timer_d;
  logic [31:0]     cmp_q, cmp_d;

  logic            aw_hs, w_hs, b_hs, ar_hs;
  logic [9:0]      cur_idx;
  logic [ID_W-1:0] cur_awid, cur_wid;
  logic [31:0]     cur_data;
  logic [3:0]      cur_strb;
  logic            commit, id_err, dec_err, wr_en;
  logic [31:0]     byte_mask;
  logic            stat_en;
  logic            sw_set, sw_clr, cmp_hit;
  logic [31:0]     rd_val;
  logic            rd_dec;

  // Readies are forced low while reset is asserted, so nothing is accepted during reset.
  assign s_awready = ~reset & ~aw_held_q & ~bvalid_q;
  assign s_wready  = ~reset & ~w_held_q & ~bvalid_q;
  assign s_arready = ~reset & ~rvalid_q;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = bvalid_q & s_bready;
  assign ar_hs = s_arvalid & s_arready;

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_bid    = bid_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;
  assign s_rid    = rid_q;
  assign s_rlast  = 1'b1;
  assign leds     = ctrl_q[1:0];
  assign irq      = pending_q & ctrl_q[8];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // A channel arriving in the commit cycle is used directly, so same-cycle AW+W commits at once.
  always_comb begin
    cur_idx  = aw_held_q ? aw_idx_q : s_awaddr[11:2];
    cur_awid = aw_held_q ? aw_id_q  : s_awid;
    cur_data = w_held_q  ? w_data_q : s_wdata;
    cur_strb = w_held_q  ? w_strb_q : s_wstrb;
    cur_wid  = w_held_q  ? w_id_q   : s_wid;
    commit   = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    id_err   = (cur_wid != cur_awid);
    dec_err  = (cur_idx >= NREGS_IDX);
    wr_en    = commit & ~id_err & ~dec_err;
  end

`ifdef AXI_REG_STRB_EN
  assign byte_mask = {{8{cur_strb[3]}}, {8{cur_strb[2]}}, {8{cur_strb[1]}}, {8{cur_strb[0]}}};
  assign stat_en   = cur_strb[0];
`else
  assign byte_mask = 32'hFFFF_FFFF;
  assign stat_en   = 1'b1;
`endif

  // Write channel capture and B response
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_id_d   = aw_id_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_id_d    = w_id_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_awaddr[11:2];
      aw_id_d   = s_awid;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
      w_id_d   = s_wid;
    end
    // Held flags stay set through the B phase; that is what keeps AW/W stalled.
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bid_d    = cur_awid;
      bresp_d  = dec_err ? 2'b11 : (id_err ? 2'b10 : 2'b00);
    end
  end

  // Register updates, timer and pending interrupt
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    cmp_d     = cmp_q;
    timer_d   = timer_q + 32'd1;
    sw_set    = 1'b0;
    sw_clr    = 1'b0;
    if (wr_en) begin
      case (cur_idx)
        10'd0: ctrl_d = merge(ctrl_q, cur_data, byte_mask) & CTRL_MASK;
        10'd1: begin
          sw_clr = stat_en & cur_data[0];
          sw_set = stat_en & cur_data[1];
        end
        10'd2: scratch_d = merge(scratch_q, cur_data, byte_mask);
        10'd4: cmp_d = merge(cmp_q, cur_data, byte_mask);
        default: ;
      endcase
    end
    cmp_hit = (cmp_q != 32'd0) && (timer_q == cmp_q);
    // A set in the same cycle as a W1C clear takes priority.
    if (cmp_hit || sw_set) begin
      pending_d = 1'b1;
    end else if (sw_clr) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Read path: data comes from the current flops, i.e. before any write committing this cycle.
  always_comb begin
    case (s_araddr[11:2])
      10'd0:   rd_val = ctrl_q;
      10'd1:   rd_val = {31'd0, pending_q};
      10'd2:   rd_val = scratch_q;
      10'd3:   rd_val = timer_q;
      10'd4:   rd_val = cmp_q;
      default: rd_val = 32'd0;
    endcase
    rd_dec   = (s_araddr[11:2] >= NREGS_IDX);
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_dec ? 32'd0 : rd_val;
      rresp_d  = rd_dec ? 2'b11 : 2'b00;
      rid_d    = s_arid;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_id_q   <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_id_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      scratch_q <= '0;
      timer_q   <= '0;
      cmp_q     <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_id_q   <= aw_id_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_id_q    <= w_id_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      scratch_q <= scratch_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
    end
  end

  // Inputs the register map does not decode.
  logic unused_inputs;
  assign unused_inputs = ^{s_awprot, s_arprot, s_awaddr[31:12], s_awaddr[1:0],
                           s_araddr[31:12], s_araddr[1:0], cur_strb};

endmodule

// File: tb/tb_axi_gp_reg_slave.sv
module tb_axi_gp_reg_slave;
  localparam int ID_W = 12;

  logic            fclk = 1'b0;
  logic            reset;
  logic [31:0]     s_awaddr;
  logic [2:0]      s_awprot;
  logic [ID_W-1:0] s_awid;
  logic            s_awvalid, s_awready;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wstrb;
  logic [ID_W-1:0] s_wid;
  logic            s_wvalid, s_wready;
  logic [1:0]      s_bresp;
  logic [ID_W-1:0] s_bid;
  logic            s_bvalid, s_bready;
  logic [31:0]     s_araddr;
  logic [2:0]      s_arprot;
  logic [ID_W-1:0] s_arid;
  logic            s_arvalid, s_arready;
  logic [31:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic [ID_W-1:0] s_rid;
  logic            s_rlast, s_rvalid, s_rready;
  logic [1:0]      leds;
  logic            irq;

  axi_gp_reg_slave #(.ID_W(ID_W), .NREGS(5)) dut (
    .fclk(fclk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awid(s_awid),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wid(s_wid),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bid(s_bid), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arid(s_arid),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .leds(leds), .irq(irq)
  );

  always #5 fclk = ~fclk;

  // Reference timer: cleared by reset, +1 every cycle otherwise.
  logic [31:0] tcnt;
  always @(posedge fclk) begin
    if (reset) tcnt <= 32'd0;
    else       tcnt <= tcnt + 32'd1;
  end

  typedef struct packed {
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } b_exp_t;

  typedef struct packed {
    logic [31:0]     data;
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  b_exp_t be;

  int n_vec = 0;
  int n_err = 0;

  // Expected register contents
  logic [31:0] m_ctrl, m_scratch, m_cmp, m_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive AW and/or W, wait (bounded) for acceptance, then drop valid.
  task automatic wr_chan(input bit use_aw, input bit use_w, input logic [31:0] addr,
                         input logic [ID_W-1:0] awid, input logic [31:0] data,
                         input logic [3:0] strb, input logic [ID_W-1:0] wid,
                         input logic [1:0] exp_resp);
    if (use_aw) bq.push_back('{resp: exp_resp, id: awid});
    s_awaddr = addr; s_awid = awid; s_awvalid = use_aw;
    s_wdata = data; s_wstrb = strb; s_wid = wid; s_wvalid = use_w;
    for (int n = 0; n < 50; n++) begin
      @(negedge fclk);
      if ((!use_aw || s_awready) && (!use_w || s_wready)) break;
    end
    chk("wr_accept", {(!use_aw || s_awready), (!use_w || s_wready)}, 2'b11);
    @(posedge fclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  // B must be valid in the cycle right after the commit cycle.
  task automatic collect_b();
    b_exp_t e;
    @(negedge fclk);
    chk("bvalid", s_bvalid, 1);
    e = bq.pop_front();
    chk("bresp", s_bresp, e.resp);
    chk("bid", s_bid, e.id);
    @(posedge fclk); #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [ID_W-1:0] id,
                    input logic [31:0] exp_data, input logic [1:0] exp_resp, input bit is_timer);
    r_exp_t e;
    s_araddr = addr; s_arid = id; s_arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge fclk);
      if (s_arready) break;
    end
    chk("ar_accept", s_arready, 1);
    rq.push_back('{data: (is_timer ? tcnt : exp_data), resp: exp_resp, id: id});
    @(posedge fclk); #1;
    s_arvalid = 1'b0;
    @(negedge fclk);
    chk("rvalid", s_rvalid, 1);
    chk("arready_busy", s_arready, 0);
    e = rq.pop_front();
    chk("rdata", s_rdata, e.data);
    chk("rresp", s_rresp, e.resp);
    chk("rid", s_rid, e.id);
    chk("rlast", s_rlast, 1);
    @(posedge fclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awid = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wid = '0; s_wvalid = 1'b0; s_bready = 1'b1;
    s_araddr = '0; s_arprot = '0; s_arid = '0; s_arvalid = 1'b0; s_rready = 1'b1;
    m_ctrl = 0; m_scratch = 0; m_cmp = 0; m_pend = 0;

    // Reset state
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    chk("rst_readies", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 5'b0);
    @(posedge fclk); #1;
    reset = 1'b0;
    @(negedge fclk);
    chk("post_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
    chk("post_rst_valids", {s_bvalid, s_rvalid}, 2'b00);
    chk("post_rst_leds_irq", {leds, irq}, 3'b000);
    chk("post_rst_resp", {s_bresp, s_rresp}, 4'b0);
    chk("post_rst_ids", {s_bid, s_rid}, 24'b0);
    chk("post_rst_rdata", s_rdata, 0);
    @(posedge fclk); #1;

    // Timer compare interrupt (done early so TIMER has not yet passed 100)
    wr_chan(1, 1, 32'h10, 12'h1, 32'd100, 4'hF, 12'h1, 2'b00); collect_b(); m_cmp = 100;
    wr_chan(1, 1, 32'h00, 12'h1, 32'h100, 4'hF, 12'h1, 2'b00); collect_b(); m_ctrl = 32'h100;
    chk("irq_before_cmp", irq, 0);
    for (int n = 0; n < 300; n++) begin
      @(negedge fclk);
      if (tcnt == 32'd100) break;
    end
    chk("irq_at_cmp", irq, 0);
    @(negedge fclk);
    chk("irq_after_cmp", irq, 1);
    @(posedge fclk); #1;
    wr_chan(1, 1, 32'h04, 12'h2, 32'h1, 4'hF, 12'h2, 2'b00); collect_b();
    chk("irq_w1c", irq, 0);
    wr_chan(1, 1, 32'h04, 12'h2, 32'h2, 4'hF, 12'h2, 2'b00); collect_b();
    chk("irq_swset", irq, 1);
    rd(32'h04, 12'h9, 32'h1, 2'b00, 0);
    wr_chan(1, 1, 32'h04, 12'h2, 32'h1, 4'hF, 12'h2, 2'b00); collect_b();
    chk("irq_w1c_again", irq, 0);

    // Same-cycle AW+W write, then read back
    wr_chan(1, 1, 32'h08, 12'h3, 32'hDEADBEEF, 4'hF, 12'h3, 2'b00); collect_b();
    m_scratch = 32'hDEADBEEF;
    rd(32'h08, 12'h7, m_scratch, 2'b00, 0);

    // W three cycles ahead of AW
    wr_chan(0, 1, 32'h0, 12'h0, 32'h3, 4'hF, 12'h5, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge fclk);
      chk("w_held_wready", s_wready, 0);
      chk("w_held_awready", s_awready, 1);
      chk("w_held_no_b", s_bvalid, 0);
    end
    @(posedge fclk); #1;
    wr_chan(1, 0, 32'h00, 12'h5, 32'h0, 4'hF, 12'h0, 2'b00); collect_b();
    m_ctrl = 32'h3;
    chk("leds", leds, 2'b11);

    // Decode errors and register integrity
    rd(32'h20, 12'h4, 32'h0, 2'b11, 0);
    wr_chan(1, 1, 32'h14, 12'h6, 32'hFFFFFFFF, 4'hF, 12'h6, 2'b11); collect_b();
    wr_chan(1, 1, 32'h0C, 12'h6, 32'h0, 4'hF, 12'h6, 2'b00); collect_b();
    rd(32'h00, 12'h1, m_ctrl, 2'b00, 0);
    rd(32'h04, 12'h1, m_pend, 2'b00, 0);
    rd(32'h08, 12'h1, m_scratch, 2'b00, 0);
    rd(32'h0C, 12'h1, 32'h0, 2'b00, 1);
    rd(32'h10, 12'h1, m_cmp, 2'b00, 0);
    rd(32'h0B, 12'h1, m_scratch, 2'b00, 0);

    // B backpressure, then WID/AWID mismatch
    s_bready = 1'b0;
    wr_chan(1, 1, 32'h08, 12'h2, 32'h12345678, 4'hF, 12'h2, 2'b00);
    m_scratch = 32'h12345678;
    s_awaddr = 32'h08; s_awid = 12'h2; s_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge fclk);
      chk("bp_bvalid", s_bvalid, 1);
      chk("bp_awready", s_awready, 0);
      chk("bp_wready", s_wready, 0);
    end
    be = bq.pop_front();
    chk("bp_bresp", s_bresp, be.resp);
    chk("bp_bid", s_bid, be.id);
    @(posedge fclk); #1;
    s_bready = 1'b1;
    @(negedge fclk);
    chk("bp_awready_pre_hs", s_awready, 0);
    @(posedge fclk); #1;
    @(negedge fclk);
    chk("bp_bvalid_cleared", s_bvalid, 0);
    chk("bp_awready_back", s_awready, 1);
    @(posedge fclk); #1;
    s_awvalid = 1'b0;
    bq.push_back('{resp: 2'b10, id: 12'h2});
    wr_chan(0, 1, 32'h0, 12'h0, 32'h00000BAD, 4'hF, 12'h1, 2'b00); collect_b();
    rd(32'h08, 12'h2, m_scratch, 2'b00, 0);

    // Byte strobes
    wr_chan(1, 1, 32'h08, 12'h3, 32'hDEADBEEF, 4'hF, 12'h3, 2'b00); collect_b();
    wr_chan(1, 1, 32'h08, 12'h3, 32'h11223344, 4'b0101, 12'h3, 2'b00); collect_b();
`ifdef AXI_REG_STRB_EN
    m_scratch = 32'hDE22BE44;
`else
    m_scratch = 32'h11223344;
`endif
    rd(32'h08, 12'h3, m_scratch, 2'b00, 0);

    // Reset with a B beat pending drops it; a W held before reset cannot commit afterwards
    s_bready = 1'b0;
    wr_chan(1, 1, 32'h08, 12'h4, 32'hCAFEF00D, 4'hF, 12'h4, 2'b00);
    bq.delete();
    @(negedge fclk);
    chk("mid_bvalid", s_bvalid, 1);
    @(posedge fclk); #1;
    wr_chan(0, 0, 32'h0, 12'h0, 32'h0, 4'h0, 12'h0, 2'b00);
    reset = 1'b1;
    s_bready = 1'b1;
    @(posedge fclk); #1;
    @(negedge fclk);
    chk("mid_rst_bvalid", s_bvalid, 0);
    chk("mid_rst_awready", s_awready, 0);
    @(posedge fclk); #1;
    reset = 1'b0;
    rd(32'h08, 12'h5, 32'h0, 2'b00, 0);
    wr_chan(0, 1, 32'h0, 12'h0, 32'h3, 4'hF, 12'h8, 2'b00);
    reset = 1'b1;
    @(posedge fclk); #1;
    reset = 1'b0;
    wr_chan(1, 0, 32'h00, 12'h8, 32'h0, 4'hF, 12'h0, 2'b00);
    bq.delete();
    @(negedge fclk);
    chk("stale_w_no_b", s_bvalid, 0);
    chk("stale_w_leds", leds, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
